// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl
//   Bank of NUM_ALARMS independent alarm channels sharing one time base.
//   Each channel stores an alarm time and runs a small FSM
//   (DISARMED / ARMED / RINGING / SNOOZED) that is advanced on sec_tick.
//   All outputs come straight from flops loaded with next-state values.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISARMED | channel ignored, no time match checks
// ARMED    | waiting for current time == stored time on a sec_tick
// RINGING  | buzzer on; cnt counts ticks toward the ring timeout
// SNOOZED  | buzzer off; cnt counts down to the next ring
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   sec_tick                   one-cycle pulse per second
//   current_24_hour/min/sec    current binary 24-hour time
//   set_alarm, alarm_sel       write strobe and addressed channel
//   alarm_input_hour/min/sec   alarm time to write
//   alarm_enable_in            1 = arm, 0 = disarm on write
//   snooze_alarm, stop_alarm   level inputs, acted on at rising edge
//   alarm_buzzer               OR of ringing_mask
//   ringing_mask, armed_mask   per-channel status
//   active_alarm               lowest-index ringing channel (0 if none)
//   set_error                  one-cycle pulse on a rejected write
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_SEC       = 5,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3,
    localparam int CW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [7:0]            current_24_hour,
    input  logic [7:0]            current_24_min,
    input  logic [7:0]            current_24_sec,
    input  logic                  set_alarm,
    input  logic [CW-1:0]         alarm_sel,
    input  logic [7:0]            alarm_input_hour,
    input  logic [7:0]            alarm_input_min,
    input  logic [7:0]            alarm_input_sec,
    input  logic                  alarm_enable_in,
    input  logic                  snooze_alarm,
    input  logic                  stop_alarm,
    output logic                  alarm_buzzer,
    output logic [NUM_ALARMS-1:0] ringing_mask,
    output logic [NUM_ALARMS-1:0] armed_mask,
    output logic [CW-1:0]         active_alarm,
    output logic                  set_error
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } state_t;

    state_t     state_q [NUM_ALARMS];
    state_t     state_d [NUM_ALARMS];
    logic [7:0] hour_q  [NUM_ALARMS];
    logic [7:0] hour_d  [NUM_ALARMS];
    logic [7:0] min_q   [NUM_ALARMS];
    logic [7:0] min_d   [NUM_ALARMS];
    logic [7:0] sec_q   [NUM_ALARMS];
    logic [7:0] sec_d   [NUM_ALARMS];
    logic [7:0] cnt_q   [NUM_ALARMS];
    logic [7:0] cnt_d   [NUM_ALARMS];
    logic [3:0] snz_q   [NUM_ALARMS];
    logic [3:0] snz_d   [NUM_ALARMS];

    logic                  snooze_prev;
    logic                  stop_prev;
    logic                  snooze_rise;
    logic                  stop_rise;
    logic                  wr_ok;
    logic [NUM_ALARMS-1:0] ring_d;
    logic [NUM_ALARMS-1:0] armed_d;
    logic [CW-1:0]         active_d;

    assign snooze_rise = snooze_alarm & ~snooze_prev;
    assign stop_rise   = stop_alarm & ~stop_prev;

    // alarm_sel is widened before the range check so that non-power-of-two
    // channel counts reject the unused codes.
    assign wr_ok = set_alarm
                && (int'({1'b0, alarm_sel}) < NUM_ALARMS)
                && (alarm_input_hour <= 8'd23)
                && (alarm_input_min  <= 8'd59)
                && (alarm_input_sec  <= 8'd59);

    always_comb begin
        state_d  = state_q;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        cnt_d    = cnt_q;
        snz_d    = snz_q;
        ring_d   = '0;
        armed_d  = '0;
        active_d = '0;

        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr_ok && (alarm_sel == CW'(i))) begin
                hour_d[i]  = alarm_input_hour;
                min_d[i]   = alarm_input_min;
                sec_d[i]   = alarm_input_sec;
                cnt_d[i]   = '0;
                snz_d[i]   = '0;
                state_d[i] = alarm_enable_in ? ARMED : DISARMED;
            end else if (stop_rise && (state_q[i] == RINGING || state_q[i] == SNOOZED)) begin
                state_d[i] = ARMED;
                cnt_d[i]   = '0;
                snz_d[i]   = '0;
            end else if (snooze_rise && state_q[i] == RINGING
                         && int'(snz_q[i]) < MAX_SNOOZE) begin
                state_d[i] = SNOOZED;
                cnt_d[i]   = 8'(SNOOZE_SEC);
                snz_d[i]   = snz_q[i] + 4'd1;
            end else if (sec_tick) begin
                case (state_q[i])
                    ARMED: begin
                        if (current_24_hour == hour_q[i] && current_24_min == min_q[i]
                            && current_24_sec == sec_q[i]) begin
                            state_d[i] = RINGING;
                            cnt_d[i]   = '0;
                        end
                    end
                    RINGING: begin
                        if (cnt_q[i] == 8'(RING_TIMEOUT_SEC - 1)) begin
                            state_d[i] = ARMED;
                            cnt_d[i]   = '0;
                            snz_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    SNOOZED: begin
                        // Tick that brings the count to zero re-rings.
                        if (cnt_q[i] <= 8'd1) begin
                            state_d[i] = RINGING;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
            ring_d[i]  = (state_d[i] == RINGING);
            armed_d[i] = (state_d[i] != DISARMED);
        end

        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_d[i]) active_d = CW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= DISARMED;
                hour_q[i]  <= '0;
                min_q[i]   <= '0;
                sec_q[i]   <= '0;
                cnt_q[i]   <= '0;
                snz_q[i]   <= '0;
            end
            snooze_prev  <= 1'b0;
            stop_prev    <= 1'b0;
            alarm_buzzer <= 1'b0;
            ringing_mask <= '0;
            armed_mask   <= '0;
            active_alarm <= '0;
            set_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            cnt_q        <= cnt_d;
            snz_q        <= snz_d;
            snooze_prev  <= snooze_alarm;
            stop_prev    <= stop_alarm;
            alarm_buzzer <= |ring_d;
            ringing_mask <= ring_d;
            armed_mask   <= armed_d;
            active_alarm <= active_d;
            set_error    <= set_alarm & ~wr_ok;
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: default 4-channel instance plus a
// 3-channel instance driven by the same stimulus to exercise the
// out-of-range channel select.
module tb_multi_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic [7:0] cur_h = '0, cur_m = '0, cur_s = '0;
    logic       set_alarm = 1'b0;
    logic [1:0] alarm_sel = '0;
    logic [7:0] in_h = '0, in_m = '0, in_s = '0;
    logic       alarm_enable_in = 1'b0;
    logic       snooze_alarm = 1'b0;
    logic       stop_alarm = 1'b0;

    logic       buzzer4, set_error4;
    logic [3:0] ringing4, armed4;
    logic [1:0] active4;
    logic       buzzer3, set_error3;
    logic [2:0] ringing3, armed3;
    logic [1:0] active3;

    int total = 0;
    int passed = 0;

    multi_alarm_ctrl u_dut4 (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .current_24_hour(cur_h), .current_24_min(cur_m), .current_24_sec(cur_s),
        .set_alarm(set_alarm), .alarm_sel(alarm_sel),
        .alarm_input_hour(in_h), .alarm_input_min(in_m), .alarm_input_sec(in_s),
        .alarm_enable_in(alarm_enable_in),
        .snooze_alarm(snooze_alarm), .stop_alarm(stop_alarm),
        .alarm_buzzer(buzzer4), .ringing_mask(ringing4), .armed_mask(armed4),
        .active_alarm(active4), .set_error(set_error4)
    );

    multi_alarm_ctrl #(.NUM_ALARMS(3)) u_dut3 (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .current_24_hour(cur_h), .current_24_min(cur_m), .current_24_sec(cur_s),
        .set_alarm(set_alarm), .alarm_sel(alarm_sel),
        .alarm_input_hour(in_h), .alarm_input_min(in_m), .alarm_input_sec(in_s),
        .alarm_enable_in(alarm_enable_in),
        .snooze_alarm(snooze_alarm), .stop_alarm(stop_alarm),
        .alarm_buzzer(buzzer3), .ringing_mask(ringing3), .armed_mask(armed3),
        .active_alarm(active3), .set_error(set_error3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        cur_h = 8'(h);
        cur_m = 8'(m);
        cur_s = 8'(s);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic write(input int sel, input int h, input int m, input int s, input logic en);
        alarm_sel = 2'(sel);
        in_h = 8'(h);
        in_m = 8'(m);
        in_s = 8'(s);
        alarm_enable_in = en;
        set_alarm = 1'b1;
        step();
        set_alarm = 1'b0;
    endtask

    initial begin
        int sc;

        // Reset
        step();
        step();
        chk("rst_armed", 32'(armed4), 32'h0);
        chk("rst_ringing", 32'(ringing4), 32'h0);
        chk("rst_buzzer", 32'(buzzer4), 32'h0);
        chk("rst_active", 32'(active4), 32'h0);
        chk("rst_set_error", 32'(set_error4), 32'h0);
        reset = 1'b0;
        step();

        // ch1 = 00:00:04, ticks from 23:59:58
        write(1, 0, 0, 4, 1'b1);
        chk("wr1_armed", 32'(armed4), 32'h2);
        chk("wr1_set_error", 32'(set_error4), 32'h0);
        tick_at(23, 59, 58);
        tick_at(23, 59, 59);
        for (int s = 0; s < 4; s++) tick_at(0, 0, s);
        chk("pre_match_ringing", 32'(ringing4), 32'h0);
        tick_at(0, 0, 4);
        chk("match_ringing", 32'(ringing4), 32'h2);
        chk("match_buzzer", 32'(buzzer4), 32'h1);
        chk("match_active", 32'(active4), 32'h1);

        // Three snoozes, each re-ringing after exactly 5 ticks
        sc = 5;
        for (int r = 0; r < 3; r++) begin
            snooze_alarm = 1'b1;
            step();
            chk("snooze_buzzer_off", 32'(buzzer4), 32'h0);
            snooze_alarm = 1'b0;
            step();
            for (int k = 0; k < 4; k++) begin
                tick_at(0, 0, sc);
                sc++;
            end
            chk("snooze_4_ticks_quiet", 32'(buzzer4), 32'h0);
            tick_at(0, 0, sc);
            sc++;
            chk("snooze_5th_tick_rings", 32'(buzzer4), 32'h1);
        end
        snooze_alarm = 1'b1;
        step();
        chk("snooze4_ignored_buzzer", 32'(buzzer4), 32'h1);
        chk("snooze4_ignored_mask", 32'(ringing4), 32'h2);
        snooze_alarm = 1'b0;
        step();
        stop_alarm = 1'b1;
        step();
        chk("stop_buzzer", 32'(buzzer4), 32'h0);
        chk("stop_armed", 32'(armed4), 32'h2);
        stop_alarm = 1'b0;
        step();

        // Ring timeout: 60 unattended ticks
        tick_at(0, 0, 4);
        chk("timeout_start_ring", 32'(buzzer4), 32'h1);
        for (int k = 0; k < 59; k++) tick_at(1, 0, k);
        chk("timeout_59_still_ring", 32'(buzzer4), 32'h1);
        tick_at(1, 1, 0);
        chk("timeout_60_silent", 32'(buzzer4), 32'h0);
        chk("timeout_armed", 32'(armed4), 32'h2);

        // ch0 and ch2 at 07:30:00, single stop
        write(0, 7, 30, 0, 1'b1);
        write(2, 7, 30, 0, 1'b1);
        chk("multi_armed", 32'(armed4), 32'h7);
        tick_at(7, 30, 0);
        chk("multi_ringing", 32'(ringing4), 32'h5);
        chk("multi_active", 32'(active4), 32'h0);
        stop_alarm = 1'b1;
        step();
        chk("multi_stop_ringing", 32'(ringing4), 32'h0);
        chk("multi_stop_buzzer", 32'(buzzer4), 32'h0);
        chk("multi_stop_armed", 32'(armed4), 32'h7);

        // Held stop level does not act again
        tick_at(7, 30, 0);
        chk("held_stop_ringing", 32'(ringing4), 32'h5);
        stop_alarm = 1'b0;
        step();

        // Snooze and stop together: stop wins, no re-ring later
        snooze_alarm = 1'b1;
        stop_alarm = 1'b1;
        step();
        chk("snz_stop_ringing", 32'(ringing4), 32'h0);
        snooze_alarm = 1'b0;
        stop_alarm = 1'b0;
        for (int k = 1; k <= 6; k++) tick_at(7, 30, k);
        chk("snz_stop_no_rering", 32'(ringing4), 32'h0);

        // Rejected writes
        write(3, 24, 0, 0, 1'b1);
        chk("err_hour_pulse", 32'(set_error4), 32'h1);
        chk("err_hour_armed", 32'(armed4), 32'h7);
        step();
        chk("err_pulse_one_cycle", 32'(set_error4), 32'h0);
        write(2, 10, 60, 0, 1'b0);
        chk("err_min_pulse", 32'(set_error4), 32'h1);
        chk("err_min_armed", 32'(armed4), 32'h7);
        write(3, 8, 0, 0, 1'b1);
        chk("wr3_ok_set_error", 32'(set_error4), 32'h0);
        chk("wr3_ok_armed", 32'(armed4), 32'hf);
        chk("sel_oob_set_error", 32'(set_error3), 32'h1);
        chk("sel_oob_armed", 32'(armed3), 32'h7);

        // Reset while snoozed
        tick_at(8, 0, 0);
        chk("ch3_ringing", 32'(ringing4), 32'h8);
        chk("ch3_active", 32'(active4), 32'h3);
        snooze_alarm = 1'b1;
        step();
        chk("ch3_snoozed", 32'(buzzer4), 32'h0);
        snooze_alarm = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_snz_armed", 32'(armed4), 32'h0);
        chk("rst_snz_ringing", 32'(ringing4), 32'h0);
        for (int k = 1; k <= 6; k++) tick_at(8, 0, k);
        tick_at(8, 0, 0);
        chk("rst_snz_no_ring", 32'(ringing4), 32'h0);
        chk("rst_snz_buzzer", 32'(buzzer4), 32'h0);
        chk("rst_snz_active", 32'(active4), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
